// File: rtl/multi_tick_gen_pkg.sv
// multi_tick_pkg: shared constants and types for multi_tick_gen.
// Optional feature macro: TICK_PHASE_EN adds a per-channel start phase to the config.
package multi_tick_pkg;
  localparam int MAX_CH    = 16;
  localparam int CH_IDX_W  = 4;
  // Config fields are carried at this fixed width; channels zero-extend into it.
  localparam int MAX_CNT_W = 32;

  typedef enum logic {IDLE, RUN} ch_state_e;

  typedef struct packed {
    logic [MAX_CNT_W-1:0] period;
    logic [MAX_CNT_W-1:0] high;
`ifdef TICK_PHASE_EN
    logic [MAX_CNT_W-1:0] phase;
`endif
  } ch_cfg_t;

  // Builds a config with any optional fields cleared.
  function automatic ch_cfg_t make_cfg(input logic [MAX_CNT_W-1:0] period,
                                       input logic [MAX_CNT_W-1:0] high);
    ch_cfg_t c;
    c        = '0;
    c.period = period;
    c.high   = high;
    return c;
  endfunction
endpackage

// File: rtl/multi_tick_gen_tick_channel.sv
// tick_channel: one periodic tick generator with a double-buffered config.
// Optional feature macro: TICK_PHASE_EN (counter starts at phase mod period).
module tick_channel
  import multi_tick_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 50
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    enable,
  input  logic    restart,
  input  logic    wr,
  input  ch_cfg_t wr_cfg,
  output logic    pending,
  output logic    tick,
  output logic    tick_rise
);

  ch_state_e        st;
  logic [CNT_W-1:0] cnt;
  ch_cfg_t          act, shd;

  logic             run_nxt, apply, start, step_up, wrap, tick_nxt;
  logic [CNT_W-1:0] cnt_nxt, start_cnt;
  ch_cfg_t          act_nxt;

  assign wrap = (MAX_CNT_W'(cnt) >= act.period - MAX_CNT_W'(1));

  // Next-state: enable low wins, then (re)start, then wrap, else count up.
  // A pending shadow lands whenever the counter is (re)aligned to its start.
  always_comb begin
    run_nxt = 1'b0;
    apply   = 1'b0;
    start   = 1'b0;
    step_up = 1'b0;
    if (!enable) begin
      apply = pending;
    end else if (st == IDLE || restart) begin
      run_nxt = 1'b1;
      apply   = pending;
      start   = 1'b1;
    end else if (wrap) begin
      run_nxt = 1'b1;
      apply   = pending;
    end else begin
      run_nxt = 1'b1;
      step_up = 1'b1;
    end
    act_nxt = apply ? shd : act;
`ifdef TICK_PHASE_EN
    start_cnt = CNT_W'(act_nxt.phase % act_nxt.period);
`else
    start_cnt = '0;
`endif
    cnt_nxt  = step_up ? cnt + CNT_W'(1) : (start ? start_cnt : '0);
    tick_nxt = run_nxt && (MAX_CNT_W'(cnt_nxt) < act_nxt.high);
  end

  // State, counter, config buffers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= IDLE;
      cnt       <= '0;
      act       <= make_cfg(MAX_CNT_W'(DEF_PERIOD), MAX_CNT_W'(DEF_PERIOD / 2));
      shd       <= make_cfg(MAX_CNT_W'(DEF_PERIOD), MAX_CNT_W'(DEF_PERIOD / 2));
      pending   <= 1'b0;
      tick      <= 1'b0;
      tick_rise <= 1'b0;
    end else begin
      st        <= run_nxt ? RUN : IDLE;
      cnt       <= cnt_nxt;
      act       <= act_nxt;
      tick      <= tick_nxt;
      tick_rise <= tick_nxt & ~tick;
      // wr only arrives with pending low, so it never collides with apply
      if (wr) begin
        shd     <= wr_cfg;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_tick_gen.sv
// multi_tick_gen: NUM_CH independent periodic tick channels sharing one config port.
// Optional feature macro: TICK_PHASE_EN (adds cfg_phase and per-channel start phase).
module multi_tick_gen
  import multi_tick_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   enable,
  input  logic                sync_restart,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_high,
`ifdef TICK_PHASE_EN
  input  logic [CNT_W-1:0]    cfg_phase,
`endif
  output logic                cfg_err,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   tick_rise
);

  logic [NUM_CH-1:0] pending, wr;
  logic              hs, per_ok, ch_ok;
  ch_cfg_t           wr_cfg;

  // Ready mirrors the target channel's pending flag; out-of-range targets are
  // accepted so that they can be flagged as errors.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (cfg_ch == CH_IDX_W'(i)) cfg_ready = ~pending[i];
  end

  assign hs     = cfg_valid & cfg_ready;
  assign per_ok = (cfg_period >= CNT_W'(2));
  assign ch_ok  = (int'(cfg_ch) < NUM_CH);

  // Request payload widened to the shared config layout.
  always_comb begin
    wr_cfg = make_cfg(MAX_CNT_W'(cfg_period), MAX_CNT_W'(cfg_high));
`ifdef TICK_PHASE_EN
    wr_cfg.phase = MAX_CNT_W'(cfg_phase);
`endif
  end

  // One-cycle error pulse for accepted but dropped requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cfg_err <= 1'b0;
    else        cfg_err <= hs & ~(per_ok & ch_ok);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr[g] = hs & per_ok & (cfg_ch == CH_IDX_W'(g));
    tick_channel #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable[g]),
      .restart   (sync_restart),
      .wr        (wr[g]),
      .wr_cfg    (wr_cfg),
      .pending   (pending[g]),
      .tick      (tick[g]),
      .tick_rise (tick_rise[g])
    );
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Bench for multi_tick_gen: directed scenarios plus a random phase, all cycles
// checked against a time-based reference model.
module tb_multi_tick_gen;
  localparam int NUM_CH = 4, CNT_W = 16, DEF_PERIOD = 50;

  logic              clk = 1'b0, reset = 1'b1;
  logic [NUM_CH-1:0] enable = '0;
  logic              sync_restart = 1'b0, cfg_valid = 1'b0;
  logic              cfg_ready, cfg_err;
  logic [3:0]        cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_period = '0, cfg_high = '0;
`ifdef TICK_PHASE_EN
  logic [CNT_W-1:0]  cfg_phase = '0;
`endif
  logic [NUM_CH-1:0] tick, tick_rise;

  always #5 clk = ~clk;

  multi_tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_PERIOD(DEF_PERIOD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sync_restart(sync_restart),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high),
`ifdef TICK_PHASE_EN
    .cfg_phase(cfg_phase),
`endif
    .cfg_err(cfg_err), .tick(tick), .tick_rise(tick_rise)
  );

  int n_cmp = 0, n_bad = 0;

  // Reference model: each running channel remembers the cycle its current
  // period began (t0); tick is high while (now - t0) mod PER < H.
  int cyc = 0;
  bit m_run[NUM_CH], m_pend[NUM_CH], m_tick[NUM_CH], m_rise[NUM_CH];
  int m_t0[NUM_CH], m_per[NUM_CH], m_hi[NUM_CH], m_sp[NUM_CH], m_sh[NUM_CH];
  bit m_err;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = 0; m_pend[c] = 0; m_tick[c] = 0; m_rise[c] = 0; m_t0[c] = 0;
      m_per[c] = DEF_PERIOD; m_hi[c] = DEF_PERIOD / 2;
      m_sp[c] = DEF_PERIOD; m_sh[c] = DEF_PERIOD / 2;
    end
    m_err = 0;
  endtask

  task automatic model_apply(int c);
    if (m_pend[c]) begin
      m_per[c] = m_sp[c]; m_hi[c] = m_sh[c]; m_pend[c] = 0;
    end
  endtask

  // Advances the model by one clock edge using the inputs sampled at it.
  task automatic model_edge();
    bit hs, ok, nt;
    int ch;
    ch = int'(cfg_ch);
    hs = cfg_valid && (ch >= NUM_CH || !m_pend[ch]);
    ok = (int'(cfg_period) >= 2) && (ch < NUM_CH);
    cyc++;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!enable[c]) begin
        m_run[c] = 0;
        model_apply(c);
      end else if (!m_run[c] || sync_restart) begin
        m_run[c] = 1;
        model_apply(c);
        m_t0[c] = cyc;
      end else if (cyc - m_t0[c] >= m_per[c]) begin
        model_apply(c);
        m_t0[c] = cyc;
      end
      nt = m_run[c] && (((cyc - m_t0[c]) % m_per[c]) < m_hi[c]);
      m_rise[c] = nt && !m_tick[c];
      m_tick[c] = nt;
    end
    if (hs && ok) begin
      m_sp[ch] = int'(cfg_period); m_sh[ch] = int'(cfg_high); m_pend[ch] = 1;
    end
    m_err = hs && !ok;
  endtask

  task automatic check_all();
    logic [NUM_CH-1:0] et, er;
    logic              erdy;
    for (int c = 0; c < NUM_CH; c++) begin
      et[c] = m_tick[c]; er[c] = m_rise[c];
    end
    erdy = (int'(cfg_ch) >= NUM_CH) ? 1'b1 : !m_pend[int'(cfg_ch)];
    chk("tick", 32'(tick), 32'(et));
    chk("tick_rise", 32'(tick_rise), 32'(er));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    chk("cfg_ready", 32'(cfg_ready), 32'(erdy));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic send(int ch, int per, int hi);
    cfg_ch = 4'(ch); cfg_period = CNT_W'(per); cfg_high = CNT_W'(hi); cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi, ri, k, n;
    // Reset state
    model_reset();
    #1 reset = 1'b0;
    #1;
    chk("rst_tick", 32'(tick), 0);
    chk("rst_rise", 32'(tick_rise), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    #10 reset = 1'b1;
    step();

    // Defaults on ch0: 1000 cycles -> 500 high, 20 rises
    enable[0] = 1'b1;
    hi = 0; ri = 0;
    repeat (1000) begin
      step();
      hi += int'(tick[0]); ri += int'(tick_rise[0]);
    end
    chk("def_high", 32'(hi), 500);
    chk("def_rises", 32'(ri), 20);

    // ch1 reprogrammed mid-period; old 50-cycle period must complete first
    enable[1] = 1'b1;
    k = 0;
    repeat (7) begin step(); k++; end
    cfg_ch = 4'd1; cfg_period = 20; cfg_high = 5; cfg_valid = 1'b1;
    #1 chk("ready_first", 32'(cfg_ready), 1);
    step(); k++;
    cfg_period = 30; cfg_high = 7;
    #1 chk("ready_second", 32'(cfg_ready), 0);
    step(); k++;
    cfg_valid = 1'b0;
    while (tick_rise[1] !== 1'b1 && k < 120) begin step(); k++; end
    chk("wrap_cycle", 32'(k), 51);
    hi = int'(tick[1]); ri = int'(tick_rise[1]);
    repeat (999) begin
      step();
      hi += int'(tick[1]); ri += int'(tick_rise[1]);
    end
    chk("ch1_high", 32'(hi), 250);
    chk("ch1_rises", 32'(ri), 50);

    // Invalid requests: PER=1, then out-of-range channel
    send(0, 1, 0);
    chk("err_per1", 32'(cfg_err), 1);
    step();
    chk("err_per1_clr", 32'(cfg_err), 0);
    send(NUM_CH, 20, 5);
    chk("err_ch", 32'(cfg_err), 1);
    step();
    chk("err_ch_clr", 32'(cfg_err), 0);
    n = 0;
    while (tick_rise[0] !== 1'b1 && n < 100) begin step(); n++; end
    n = 0;
    do begin step(); n++; end while (tick_rise[0] !== 1'b1 && n < 100);
    chk("ch0_period_kept", 32'(n), 50);

    // H=0 -> never high; H=PER -> constant high, one rise
    send(2, 10, 0);
    step();
    enable[2] = 1'b1;
    ri = 0;
    repeat (200) begin step(); ri += int'(tick_rise[2]); end
    chk("h0_rises", 32'(ri), 0);
    enable[2] = 1'b0;
    step();
    send(2, 10, 10);
    step();
    enable[2] = 1'b1;
    hi = 0; ri = 0;
    repeat (200) begin
      step();
      hi += int'(tick[2]); ri += int'(tick_rise[2]);
    end
    chk("hfull_high", 32'(hi), 200);
    chk("hfull_rises", 32'(ri), 1);

    // sync_restart aligns ch0 (PER=10) and ch1 (PER=15); a coincident
    // request to ch1 waits for the following wrap
    enable[1:0] = 2'b00;
    step();
    send(0, 10, 3);
    send(1, 15, 5);
    step();
    enable[1:0] = 2'b11;
    repeat ($urandom_range(3, 40)) step();
    n = 0;
    while ((m_tick[0] || m_tick[1]) && n < 40) begin step(); n++; end
    sync_restart = 1'b1;
    cfg_ch = 4'd1; cfg_period = 12; cfg_high = 2; cfg_valid = 1'b1;
    step();
    sync_restart = 1'b0; cfg_valid = 1'b0;
    chk("restart_rise", 32'(tick_rise[1:0]), 32'h3);
    repeat (40) step();

    // Async reset mid-high, then default period/high on restart
    n = 0;
    while (tick[0] !== 1'b1 && n < 20) begin step(); n++; end
    #1 reset = 1'b0;
    #1;
    chk("async_tick", 32'(tick), 0);
    chk("async_rise", 32'(tick_rise), 0);
    chk("async_ready", 32'(cfg_ready), 1);
    model_reset();
    #1 reset = 1'b1;
    hi = 0; ri = 0;
    repeat (50) begin
      step();
      hi += int'(tick[0]); ri += int'(tick_rise[0]);
    end
    chk("post_rst_high", 32'(hi), 25);
    chk("post_rst_rises", 32'(ri), 1);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 40) == 0) begin
        k = $urandom_range(0, NUM_CH - 1);
        enable[k] = ~enable[k];
      end
      sync_restart = ($urandom_range(0, 30) == 0);
      cfg_valid    = ($urandom_range(0, 5) == 0);
      cfg_ch       = 4'($urandom_range(0, 5));
      cfg_period   = CNT_W'($urandom_range(0, 20));
      cfg_high     = CNT_W'($urandom_range(0, 22));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_tick_gen.md
MULTI_TICK_GEN -- requirements
Module: multi_tick_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent tick channels (1..16).
REQ-002 Parameter CNT_W, default 16: period/high counter width in bits.
REQ-003 Parameter DEF_PERIOD, default 50: reset period in clk cycles (2..2^CNT_W-1); reset high time is DEF_PERIOD/2, rounded down.
REQ-004 clk  input  1  clock clk, all state updates on rising edge.
REQ-005 reset  input  1  reset reset, asynchronous, active-low.
REQ-006 enable  input  NUM_CH  per-channel run enable.
REQ-007 sync_restart  input  1  one-cycle pulse; phase-aligns all channels.
REQ-008 cfg_valid  input  1  configuration request valid.
REQ-009 cfg_ready  output  1  configuration request accepted when high with cfg_valid.
REQ-010 cfg_ch  input  4  target channel index.
REQ-011 cfg_period  input  CNT_W  new period PER in cycles.
REQ-012 cfg_high  input  CNT_W  new high time H in cycles.
REQ-013 cfg_err  output  1  one-cycle pulse on an accepted but invalid request.
REQ-014 tick  output  NUM_CH  registered periodic waveform per channel.
REQ-015 tick_rise  output  NUM_CH  registered one-cycle pulse, coincident with the first high cycle of each tick period.

Function
REQ-016 Each channel SHALL hold an active counter cnt (0..PER-1), active PER/H, and a shadow PER/H with a pending flag.
REQ-017 Channel states: IDLE (enable low) and RUN; IDLE forces cnt=0, tick=0, tick_rise=0.
REQ-018 IDLE->RUN when enable samples 1; the first tick cycle (cnt=0) is the next clock cycle.
REQ-019 RUN->IDLE when enable samples 0; tick is 0 the following cycle, with no partial-period completion.
REQ-020 In RUN: tick=1 while cnt<H, else 0; cnt wraps from PER-1 to 0.
REQ-021 tick_rise=1 only on a cycle where tick goes 0->1.
REQ-022 H=0 SHALL give a constant-low tick; H>=PER SHALL give a constant-high tick, with a single tick_rise on entering RUN.
REQ-023 A handshake occurs when cfg_valid and cfg_ready are both 1; cfg_ready = NOT pending[cfg_ch].
REQ-024 An accepted request is invalid if PER<2 or cfg_ch>=NUM_CH; it is dropped, with cfg_err=1 on the next cycle.
REQ-025 An accepted valid request writes the shadow and sets pending.
REQ-026 Pending shadow is applied on the cycle cnt wraps (PER-1->0), or on the next cycle if the channel is in IDLE; pending then clears.
REQ-027 sync_restart SHALL set cnt=0 on every RUN channel on the next cycle and apply any pending shadows at the same instant.
REQ-028 sync_restart coincident with a handshake: the new request goes to the shadow and is applied at the following wrap, not at this restart.
REQ-029 enable rising coincident with sync_restart behaves as plain IDLE->RUN.

Reset
REQ-030 Reset assertion SHALL immediately clear tick, tick_rise, cfg_err, cnt and pending, and force IDLE, regardless of mid-period state.
REQ-031 On reset, active PER=DEF_PERIOD and H=DEF_PERIOD/2; cfg_ready reads 1 after reset.

Configuration
REQ-032 With TICK_PHASE_EN defined, a cfg_phase input (CNT_W) is present and stored per channel with the config; on IDLE->RUN or sync_restart, cnt starts at phase mod PER.
REQ-033 Without TICK_PHASE_EN, the cfg_phase port and its storage are absent, and cnt always starts at 0.

Structure
REQ-034 Package multi_tick_pkg SHALL hold MAX_CH=16, CH_IDX_W=4, the channel state enum (IDLE, RUN) and the channel config struct (period, high, optional phase).
REQ-035 Sub-module tick_channel SHALL implement one channel (counter, shadow, pending, outputs), instantiated NUM_CH times by generate.
REQ-036 The top level SHALL contain only handshake decode, error detection and restart fan-out.

Verification
REQ-037 Defaults, enable[0]=1 for 1000 cycles -> 500 tick-high cycles, 20 tick_rise pulses.
REQ-038 ch1 reprogrammed mid-period to PER=20, H=5 -> old period completes; then over 1000 cycles 250 high and 50 rises; a second request before the wrap sees cfg_ready=0.
REQ-039 cfg_period=1, and separately cfg_ch=NUM_CH -> cfg_err pulses once each; active config unchanged (period still 50).
REQ-040 H=0 -> 0 rises over 200 cycles; H=PER=10 -> tick constantly 1 with exactly 1 rise.
REQ-041 ch0 PER=10, ch1 PER=15, sync_restart at an arbitrary cycle -> both tick_rise pulses coincide on the next cycle.
REQ-042 Reset asserted mid-high -> tick=0 without waiting for a clock edge; after release, enabled channels restart with PER=50, H=25.
